data_memory_pipelined: RTL
==========================

Name: data_memory_pipelined

Overview:
- Parametrised successor to the single-cycle data memory behind the RISC-V core's load/store port.
- Word-organised RAM with a configurable data width, depth and read latency, plus byte-lane write enables.
- Adds a valid/ready request handshake, in-order pipelined responses, alignment and range error reporting, and a post-reset clear sequence.
- Lets the core move to a multi-cycle or pipelined memory interface without changing the memory contract per generation.

Parameters:
- DATA_WIDTH, 32, word width in bits; a multiple of 8; BYTES = DATA_WIDTH/8.
- DEPTH, 1024, number of words; power of two.
- ADDR_WIDTH, 32, width of the byte address.
- READ_LATENCY, 1, cycles from request accept to response; legal range 1..4.
- CLEAR_ON_RESET, 1, when 1 the RAM is zero-filled after reset before requests are accepted.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  BYTES  per-byte write enable; all zero = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  write data, lane i = bits [8i+7:8i].
- rsp_valid  out  1  response present for exactly one cycle.
- rsp_rdata  out  DATA_WIDTH  read data; zero for writes and errored requests.
- rsp_err  out  1  request was misaligned or out of range.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Latency pipeline flushed; clear counter = 0.
  - State = INIT if CLEAR_ON_RESET=1, else READY.
  - RAM contents are not reset asynchronously.
- FSM states: INIT, READY.
  - INIT: writes zero to word[clear_cnt] each cycle and increments clear_cnt. After the word DEPTH-1 write, moves to READY. Takes exactly DEPTH cycles. req_ready=0 throughout.
  - READY: req_ready=1 permanently; no other exit except reset.
- Accept: a request is accepted on the rising edge where req_valid && req_ready. One request can be accepted per cycle.
- Word index = req_addr[log2(BYTES)+log2(DEPTH)-1 : log2(BYTES)].
- Error conditions, evaluated on the accepted request:
  - misaligned: req_addr[log2(BYTES)-1:0] != 0;
  - out of range: req_addr >= DEPTH*BYTES.
  - If either holds: no RAM access, rsp_err=1, rsp_rdata=0.
- Write (any req_we bit set, no error):
  - Lanes with req_we[i]=1 are updated at the accept edge; other lanes are unchanged.
  - The write still produces a response: rsp_valid=1, rsp_rdata=0, rsp_err=0.
- Read (req_we=0, no error): rsp_rdata = the word value as of the accept edge.
- Latency and ordering:
  - Every accepted request produces exactly one response.
  - The response is asserted READ_LATENCY cycles after the accept edge.
  - Responses are strictly in accept order.
  - Back-to-back accepts give back-to-back responses.
  - There is no response backpressure.
- Hazards:
  - A read accepted the cycle after a write to the same word returns the new data.
  - A write and read cannot coincide; there is a single request port.
- Reset mid-operation: in-flight responses are dropped (rsp_valid=0), and INIT restarts from word 0.
- Boundaries:
  - Address DEPTH*BYTES-BYTES is valid.
  - Address DEPTH*BYTES is an error.
  - Wide addresses with upper bits set are errors; no alias wrap.
- Width rule: rsp_rdata lanes map 1:1 to req_wdata lanes (little-endian byte lanes).

Test Plan:
- Reset + clear: set DEPTH=16, CLEAR_ON_RESET=1, pre-load nonzero values, release rst_n.
  - req_ready stays 0 for 16 cycles, then rises.
  - A read of addr 0x3C returns 0x00000000.
- Byte-enable write: write 0xDEADBEEF to 0x10 with we=1111, then 0x000000AA with we=0001, then read 0x10.
  - Read returns 0xDEADBEAA, rsp_err=0.
- Latency: with READ_LATENCY=3, issue reads on 4 consecutive cycles to words holding 1, 2, 3, 4.
  - rsp_valid is high on accept+3 .. accept+6.
  - Data comes back as 1, 2, 3, 4, in order.
- Errors: read 0x12 (misaligned) and 4*DEPTH (out of range).
  - Both give rsp_err=1, rsp_rdata=0.
  - A write to 0x12 with we=1111 leaves word 4 unchanged.
- Read-after-write: write 0x12345678 to 0x20, then read 0x20 on the next cycle.
  - Response is 0x12345678.
- Reset mid-flight: with READ_LATENCY=2, accept a read, then pulse rst_n low 1 cycle later.
  - No rsp_valid is seen.
  - req_ready=0 for DEPTH cycles after release.

Source files
------------

// File: rtl/data_memory_pipelined.sv
// Word-organised data RAM with byte-lane writes, a valid/ready request port,
// fixed-latency in-order responses, address error reporting and post-reset clear.
module data_memory_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = 32,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [DATA_WIDTH/8-1:0]   req_we,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH * BYTES);

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // its response appears READ_LATENCY cycles later, in order, with no backpressure.

  typedef enum logic {INIT, READY} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   clear_cnt, clear_next;
  logic               accept, is_write, misaligned, out_of_range, addr_err;
  logic [IDX_W-1:0]   idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_err;
  logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

  assign accept       = req_valid && req_ready;
  assign is_write     = |req_we;
  assign misaligned   = |(req_addr & ALIGN_MASK);
  assign out_of_range = {1'b0, req_addr} >= ADDR_LIMIT;
  assign addr_err     = misaligned || out_of_range;
  assign idx          = req_addr[OFF_W +: IDX_W];

  always_comb begin
    state_next = state;
    clear_next = clear_cnt;
    case (state)
      INIT: begin
        clear_next = clear_cnt + 1'b1;
        if (clear_cnt == IDX_W'(DEPTH - 1)) state_next = READY;
      end
      READY: state_next = READY;
      default: state_next = READY;
    endcase
  end

  // req_ready is registered so it stays low while rst_n is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= (CLEAR_ON_RESET != 0) ? INIT : READY;
      clear_cnt <= '0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_next;
      clear_cnt <= clear_next;
      req_ready <= (state_next == READY);
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clear_cnt] <= '0;
    end else if (accept && is_write && !addr_err) begin
      for (int i = 0; i < BYTES; i++) begin
        if (req_we[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Stage 0 captures the pre-write word value at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_err[0]   <= accept && addr_err;
      pipe_data[0]  <= (accept && !addr_err && !is_write) ? mem[idx] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign rsp_valid = pipe_valid[READ_LATENCY-1];
  assign rsp_err   = pipe_err[READ_LATENCY-1];
  assign rsp_rdata = pipe_data[READ_LATENCY-1];

endmodule
